// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory bus bundle for mem_arbiter.
// slave: arbiter side; master: requesters and memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_size, d_unsigned,
    input  d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_size, d_unsigned,
    output d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port 1-cycle memory.
// Ports: clk, rst (sync, high), bus (mem_arbiter_if.slave),
// stat_if_cnt/stat_d_cnt (live only with MEM_ARB_STATS_EN).
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic [31:0] stat_if_cnt,
  output logic [31:0] stat_d_cnt
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic [1:0] size_q, off_q;
  logic       uns_q, err_q, store_q;
  logic       err_d, store_d;

  logic       if_win, d_win, mis;
  logic       sz_b, sz_h;
  logic [3:0] we_l;
  logic [31:0] wd_r;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld;

  // Fetch only beats a concurrent data request once starved out.
  assign if_win = !rst && bus.if_req &&
                  (!bus.d_req || starve_q == SMAX);
  assign d_win  = !rst && bus.d_req && !if_win;

  assign sz_b = bus.d_size == 2'd0;
  assign sz_h = bus.d_size == 2'd1;
  assign mis  = (sz_h && bus.d_addr[0]) ||
                (bus.d_size[1] && bus.d_addr[1:0] != 2'b00);

  always_comb begin
    we_l = 4'b1111;
    wd_r = bus.d_wdata;
    unique case (1'b1)
      sz_b: begin
        we_l = 4'b0001 << bus.d_addr[1:0];
        wd_r = {4{bus.d_wdata[7:0]}};
      end
      sz_h: begin
        we_l = 4'b0011 << {bus.d_addr[1], 1'b0};
        wd_r = {2{bus.d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.if_gnt    = if_win;
    bus.d_gnt     = d_win;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    owner_d       = OWN_NONE;
    err_d         = 1'b0;
    store_d       = 1'b0;
    unique case (1'b1)
      if_win: begin
        owner_d      = OWN_IF;
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr[ADDR_W-1:2];
      end
      d_win: begin
        owner_d = OWN_D;
        err_d   = mis;
        store_d = bus.d_we;
        if (!mis) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.d_addr[ADDR_W-1:2];
          if (bus.d_we) begin
            bus.mem_we    = we_l;
            bus.mem_wdata = wd_r;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = 4'd0;
    if (bus.if_req && !if_win)
      starve_d = (starve_q == SMAX) ? SMAX : starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      size_q   <= 2'd0;
      off_q    <= 2'd0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      size_q   <= bus.d_size;
      off_q    <= bus.d_addr[1:0];
      uns_q    <= bus.d_unsigned;
      err_q    <= err_d;
      store_q  <= store_d;
    end
  end

  assign ld_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_h = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld = bus.mem_rdata;
    if (size_q == 2'd0)
      ld = {{24{~uns_q & ld_b[7]}}, ld_b};
    else if (size_q == 2'd1)
      ld = {{16{~uns_q & ld_h[15]}}, ld_h};
  end

  // Gating with rst cancels a response already in flight.
  assign bus.if_rvalid = !rst && owner_q == OWN_IF;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = !rst && owner_q == OWN_D;
  assign bus.d_err     = bus.d_rvalid && err_q;
  assign bus.d_rdata   =
    (bus.d_rvalid && !err_q && !store_q) ? ld : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_cnt <= '0;
      stat_d_cnt  <= '0;
    end else begin
      if (if_win) stat_if_cnt <= stat_if_cnt + 32'd1;
      if (d_win)  stat_d_cnt  <= stat_d_cnt + 32'd1;
    end
  end
`else
  assign stat_if_cnt = '0;
  assign stat_d_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter.
// Byte-level reference model; memory modelled as 16 words.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] stat_if_cnt, stat_d_cnt;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stat_if_cnt(stat_if_cnt),
    .stat_d_cnt(stat_d_cnt)
  );

  logic [31:0] ram [16];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i])
          ram[bus.mem_addr[3:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      bus.mem_rdata <= ram[bus.mem_addr[3:0]];
    end
  end

  logic [7:0] ref_b [64];
  int starve, n_if, n_d;
  logic e_if_v, e_d_v, e_d_err;
  logic [31:0] e_if_d, e_d_d;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle_chk(input logic with_stats);
    check("rst_if_gnt", 32'(bus.if_gnt), 0);
    check("rst_d_gnt", 32'(bus.d_gnt), 0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 0);
    check("rst_d_err", 32'(bus.d_err), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    if (with_stats) begin
      check("rst_stat_if", stat_if_cnt, 0);
      check("rst_stat_d", stat_d_cnt, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_size = 2'd2;
    bus.d_addr = 32'h8;
    #1 idle_chk(1'b0);
    @(negedge clk);
    #1 idle_chk(1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    starve = 0;
    n_if = 0;
    n_d = 0;
    e_if_v = 1'b0;
    e_d_v = 1'b0;
    e_d_err = 1'b0;
  endtask

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe,
                      input logic [1:0] dsz, input logic duns,
                      input logic [31:0] da, input logic [31:0] dwd,
                      output logic gi, output logic gd);
    logic mis;
    int nb, a, fa;
    logic [31:0] v, rep;
    logic [3:0] we;
    @(negedge clk);
    bus.if_req = ir;
    bus.if_addr = ia;
    bus.d_req = dr;
    bus.d_we = dwe;
    bus.d_size = dsz;
    bus.d_unsigned = duns;
    bus.d_addr = da;
    bus.d_wdata = dwd;
    #1;
    check("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_v));
    if (e_if_v) check("if_rdata", bus.if_rdata, e_if_d);
    check("d_rvalid", 32'(bus.d_rvalid), 32'(e_d_v));
    if (e_d_v) begin
      check("d_err", 32'(bus.d_err), 32'(e_d_err));
      check("d_rdata", bus.d_rdata, e_d_d);
    end
`ifdef MEM_ARB_STATS_EN
    check("stat_if", stat_if_cnt, 32'(n_if));
    check("stat_d", stat_d_cnt, 32'(n_d));
`else
    check("stat_if", stat_if_cnt, 0);
    check("stat_d", stat_d_cnt, 0);
`endif
    gi = ir && (!dr || starve == SM);
    gd = dr && !gi;
    check("if_gnt", 32'(bus.if_gnt), 32'(gi));
    check("d_gnt", 32'(bus.d_gnt), 32'(gd));
    nb = (dsz == 2'd0) ? 1 : (dsz == 2'd1) ? 2 : 4;
    a = int'(da[5:0]);
    mis = gd && (a % nb != 0);
    check("mem_en", 32'(bus.mem_en), 32'(gi || (gd && !mis)));
    e_d_d = 32'd0;
    if (gi) begin
      check("mem_addr_if", 32'(bus.mem_addr), ia >> 2);
      check("mem_we_if", 32'(bus.mem_we), 0);
      fa = int'(ia[5:0]) & 60;
      v = 0;
      for (int k = 0; k < 4; k++) v |= 32'(ref_b[fa+k]) << (8*k);
      e_if_d = v;
    end else if (gd && !mis) begin
      check("mem_addr_d", 32'(bus.mem_addr), da >> 2);
      if (dwe) begin
        we = 4'b0000;
        for (int k = 0; k < nb; k++) we[(a % 4) + k] = 1'b1;
        rep = (nb == 1) ? 32'(dwd[7:0]) * 32'h01010101 :
              (nb == 2) ? 32'(dwd[15:0]) * 32'h00010001 : dwd;
        check("mem_we_st", 32'(bus.mem_we), 32'(we));
        check("mem_wdata", bus.mem_wdata, rep);
        for (int k = 0; k < nb; k++) ref_b[a+k] = dwd[8*k +: 8];
      end else begin
        check("mem_we_ld", 32'(bus.mem_we), 0);
        v = 0;
        for (int k = 0; k < nb; k++) v |= 32'(ref_b[a+k]) << (8*k);
        if (!duns && nb < 4 && v[8*nb-1])
          v = v | ~((32'd1 << (8*nb)) - 32'd1);
        e_d_d = v;
      end
    end else begin
      check("mem_addr_idle", 32'(bus.mem_addr), 0);
      check("mem_wdata_idle", bus.mem_wdata, 0);
    end
    e_if_v = gi;
    e_d_v = gd;
    e_d_err = mis;
    if (ir && !gi) starve = (starve >= SM) ? SM : starve + 1;
    else starve = 0;
    if (gi) n_if++;
    if (gd) n_d++;
  endtask

  logic gi, gd;
  logic pi, pd, dwe, duns;
  logic [1:0] dsz;
  logic [31:0] ia, da, dwd, w;
  int nd;

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_size = 2'd0;
    bus.d_unsigned = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w[8*k +: 8];
    end
    do_reset();

    step(1, 32'h100, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 1, 1, 0, 0, 32'h203, 32'hAB, gi, gd);
    step(0, 0, 1, 1, 2, 0, 32'h4, 32'h80F07F81, gi, gd);
    step(0, 0, 1, 0, 0, 0, 32'h4, 0, gi, gd);
    step(0, 0, 1, 0, 0, 1, 32'h4, 0, gi, gd);
    step(0, 0, 1, 0, 1, 0, 32'h6, 0, gi, gd);
    step(0, 0, 1, 0, 1, 1, 32'h6, 0, gi, gd);
    step(0, 0, 1, 0, 2, 0, 32'h102, 0, gi, gd);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

    nd = 0;
    for (int c = 0; c < 15; c++) begin
      step(1, 32'h20, 1, 0, 2, 0, 32'h8, 0, gi, gd);
      if (gd) nd++;
      else begin
        check("contend_run", 32'(nd), SM);
        nd = 0;
      end
    end

    step(0, 0, 1, 0, 2, 0, 32'h8, 0, gi, gd);
    do_reset();

    pi = 1'b0;
    pd = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pi) begin
        pi = $urandom_range(0, 2) != 0;
        ia = $urandom_range(0, 63);
      end
      if (!pd) begin
        pd = $urandom_range(0, 2) != 0;
        dwe = $urandom_range(0, 1) == 1;
        dsz = 2'($urandom_range(0, 3));
        duns = $urandom_range(0, 1) == 1;
        da = $urandom_range(0, 63);
        dwd = $urandom;
      end
      step(pi, ia, pd, dwe, dsz, duns, da, dwd, gi, gd);
      if (gi) pi = 1'b0;
      if (gd) pd = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified code/data memory between the instruction-fetch requester and the load/store data requester.
- Arbitrates each cycle and issues at most one memory access per cycle.
- Generates byte-lane write enables for sb/sh/sw and sign/zero-extends lb/lbu/lh/lhu/lw read data.
- Returns responses one cycle after grant, matching the memory's 1-cycle synchronous read. Sits between the core's fetch/LSU stages and the memory array.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- STARVE_MAX, 4, consecutive cycles a pending fetch may lose to data before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch byte address (bits [1:0] ignored)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (one cycle after if_gnt)
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request, held with all attributes until d_gnt
- d_we  in  1  1=store, 0=load
- d_size  in  2  0=byte, 1=half, 2=word (3 is treated as word)
- d_unsigned  in  1  zero-extend load (lbu/lhu)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (loads and stores)
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  misaligned access, qualified by d_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte-lane write enables, lane i = bits [8i+7:8i]
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word, valid the cycle after mem_en
- stat_if_cnt  out  32  fetch grant count (optional feature)
- stat_d_cnt  out  32  data grant count (optional feature)

Behaviour:
- Reset: all outputs 0; starvation counter 0; owner register = NONE. Reset mid-response cancels the pending rvalid.
- Arbitration is combinational within the cycle; at most one of if_gnt/d_gnt is high.
  - Only one requester active → it is granted.
  - Both active → data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt (4 bits):
  - +1 each cycle if_req is high and if_gnt is low.
  - Cleared on if_gnt or when if_req is low.
  - Saturates at STARVE_MAX.
- Granted fetch: mem_en=1, mem_we=0, mem_addr=if_addr[ADDR_W-1:2].
- Granted data with misaligned address (half with addr[0]=1; word with addr[1:0]≠0):
  - mem_en=0, no memory write.
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- Granted aligned store: mem_en=1.
  - mem_we: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<{addr[1],1'b0}; word → 4'b1111.
  - mem_wdata replicates the byte ×4 or the half ×2.
  - Next cycle: d_rvalid=1, d_rdata=0.
- Granted aligned load: mem_en=1, mem_we=0. Next cycle, from mem_rdata:
  - Select lane by registered addr[1:0] and size.
  - Sign-extend unless the registered d_unsigned is set.
  - d_rvalid=1.
- Response timing:
  - Registered owner/size/offset/unsigned/err capture the grant.
  - rvalid pulses exactly one cycle; if_rdata = mem_rdata when if_rvalid.
  - Back-to-back grants every cycle are legal, giving full throughput.
- Request attributes changing while a request is ungranted are a protocol violation; the block samples them only on the grant cycle.
- mem_en is low in any cycle without a grant; mem_addr/mem_wdata are don't-care then but driven 0.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - stat_if_cnt and stat_d_cnt increment on each if_gnt / d_gnt, misaligned grants included.
  - 32-bit counters that wrap at 2^32; cleared by rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100 → same cycle if_gnt=1, mem_en=1, mem_addr=0x40; next cycle if_rvalid=1, if_rdata=mem_rdata.
- Continuous contention: if_req and d_req high every cycle, STARVE_MAX=4 → 4 d_gnt, then 1 if_gnt, repeating.
- Store byte: d_we=1, size=0, addr=0x203, wdata=0xAB → mem_we=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x80; d_rvalid next cycle with d_err=0.
- Loads: mem_rdata=0x80F0_7F81.
  - lb at offset 0 → 0xFFFFFF81; lbu at offset 0 → 0x00000081.
  - lh at offset 2 → 0xFFFF80F0; lhu at offset 2 → 0x000080F0.
- Misaligned: lw at 0x102 → d_gnt=1, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0. Memory content unchanged.
- Reset: rst asserted the cycle after a load grant → d_rvalid stays 0; all outputs 0. With MEM_ARB_STATS_EN, counters read 0 after reset.
